pipe_stage_elastic: RTL

- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one control bundle and one data bundle between adjacent stages using a valid/ready handshake.
- A 2-entry skid buffer holds the stage without a combinational ready path, so a downstream stall is absorbed without losing a transfer.
- Synchronous flush squashes in-flight entries into bubbles (control zeroed); a saturating counter records upstream stall cycles for hazard profiling.

---
 rtl/pipe_stage_elastic_if.sv | 25 ++
 rtl/pipe_stage_elastic.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready link bundle for pipe_stage_elastic: upstream (in_*) and downstream (out_*) sides.
// slave is the stage's view; master is the surrounding pipeline's view.
interface pipe_stage_elastic_if #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: 2-entry skid buffer carrying {ctrl, data},
// with synchronous flush to bubbles and a saturating upstream-stall counter.
module pipe_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 cnt_clr,
  pipe_stage_elastic_if.slave  bus,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  // Encoding doubles as the entry count driven on occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [CTRL_W-1:0]  main_ctrl_r, main_ctrl_s;
  logic [DATA_W-1:0]  main_data_r, main_data_s;
  logic [CTRL_W-1:0]  skid_ctrl_r, skid_ctrl_s;
  logic [DATA_W-1:0]  skid_data_r, skid_data_s;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic               in_ready_s;
  logic               out_valid_s;
  logic               in_fire_s;
  logic               out_fire_s;

  // Handshake flags depend on the state register only; out_ready never reaches in_ready.
  always_comb begin
    in_ready_s  = (state_r != FULL);
    out_valid_s = (state_r != EMPTY);
    in_fire_s   = bus.in_valid & in_ready_s;
    out_fire_s  = out_valid_s & bus.out_ready;
  end

  // Next-state and storage update; flush overrides every transition.
  always_comb begin
    state_s     = state_r;
    main_ctrl_s = main_ctrl_r;
    main_data_s = main_data_r;
    skid_ctrl_s = skid_ctrl_r;
    skid_data_s = skid_data_r;
    if (flush) begin
      state_s     = EMPTY;
      main_ctrl_s = '0;
      main_data_s = '0;
      skid_ctrl_s = '0;
      skid_data_s = '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            main_ctrl_s = bus.in_ctrl;
            main_data_s = bus.in_data;
            state_s     = HALF;
          end else begin
            state_s = EMPTY;
          end
        end
        HALF: begin
          if (in_fire_s && !out_fire_s) begin
            skid_ctrl_s = bus.in_ctrl;
            skid_data_s = bus.in_data;
            state_s     = FULL;
          end else if (in_fire_s && out_fire_s) begin
            main_ctrl_s = bus.in_ctrl;
            main_data_s = bus.in_data;
            state_s     = HALF;
          end else if (out_fire_s) begin
            state_s = EMPTY;
          end else begin
            state_s = HALF;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            main_ctrl_s = skid_ctrl_r;
            main_data_s = skid_data_r;
            state_s     = HALF;
          end else begin
            state_s = FULL;
          end
        end
        default: begin
          state_s = EMPTY;
        end
      endcase
    end
  end

  // State and entry storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      main_ctrl_r <= '0;
      main_data_r <= '0;
      skid_ctrl_r <= '0;
      skid_data_r <= '0;
    end else begin
      state_r     <= state_s;
      main_ctrl_r <= main_ctrl_s;
      main_data_r <= main_data_s;
      skid_ctrl_r <= skid_ctrl_s;
      skid_data_r <= skid_data_s;
    end
  end

  // Saturating count of blocked upstream cycles; clear wins, flush is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (cnt_clr) begin
      stall_cnt_r <= '0;
    end else if (bus.in_valid && !in_ready_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_ctrl  = out_valid_s ? main_ctrl_r : {CTRL_W{1'b0}};
  assign bus.out_data  = main_data_r;
  assign occupancy     = state_r;
  assign stall_cnt     = stall_cnt_r;

endmodule
